// File: rtl/aes_spi_if_if.sv
// Bus bundle for aes_spi_if: SPI pins towards the host plus the start/done handshake towards the AES core.
interface aes_spi_if_if #(
    parameter int KEY_W  = 128,
    parameter int DATA_W = 128
);
    logic              sck;
    logic              sdi;
    logic              load;
    logic              sdo;
    logic              done;
    logic              err;
    logic              core_start;
    logic [KEY_W-1:0]  core_key;
    logic [DATA_W-1:0] core_pt;
    logic              core_done;
    logic [DATA_W-1:0] core_ct;

    modport slave (
        input  sck, sdi, load, core_done, core_ct,
        output sdo, done, err, core_start, core_key, core_pt
    );

    modport master (
        output sck, sdi, load, core_done, core_ct,
        input  sdo, done, err, core_start, core_key, core_pt
    );
endinterface

// File: rtl/aes_spi_if.sv
// SPI slave front end for the AES core: {plaintext, key} frame in, one-shot core launch, cyphertext out.
// Define AES_SPI_KEY_REUSE_EN to also accept plaintext-only frames that reuse the last loaded key.
module aes_spi_if #(
    parameter int KEY_W  = 128,
    parameter int DATA_W = 128
) (
    input  logic        clk,
    input  logic        reset,
    aes_spi_if_if.slave bus
);
    localparam int FRAME_W = DATA_W + KEY_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int OCNT_W  = $clog2(DATA_W + 1);

    generate
        if (DATA_W != 128) begin : gBadDataW
            $error("aes_spi_if: DATA_W must be 128");
        end
        if (KEY_W != 128 && KEY_W != 192 && KEY_W != 256) begin : gBadKeyW
            $error("aes_spi_if: KEY_W must be 128, 192 or 256");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, SHIFT_IN, START, WAIT_CORE, SHIFT_OUT} state_t;

    logic [1:0]        sckSync_q, sdiSync_q, loadSync_q;
    logic              sckPrev_q, loadPrev_q;
    logic              sckRise, sckFall, loadRise, loadFall;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bitCnt_q, bitCnt_d, cntInc;
    logic              ovf_q, ovf_d, ovfInc;
    logic [FRAME_W-1:0] inShift_q, inShift_d, shiftInc;
    logic [DATA_W-1:0] outShift_q, outShift_d;
    logic [OCNT_W-1:0] outCnt_q, outCnt_d;
    logic              done_q, done_d, err_q, err_d, coreStart_q;
    logic [KEY_W-1:0]  coreKey_q, coreKey_d;
    logic [DATA_W-1:0] corePt_q, corePt_d;
`ifdef AES_SPI_KEY_REUSE_EN
    logic              keyValid_q, keyValid_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sckSync_q  <= '0;
            sdiSync_q  <= '0;
            loadSync_q <= '0;
            sckPrev_q  <= 1'b0;
            loadPrev_q <= 1'b0;
        end else begin
            sckSync_q  <= {sckSync_q[0], bus.sck};
            sdiSync_q  <= {sdiSync_q[0], bus.sdi};
            loadSync_q <= {loadSync_q[0], bus.load};
            sckPrev_q  <= sckSync_q[1];
            loadPrev_q <= loadSync_q[1];
        end
    end

    assign sckRise  = sckSync_q[1] & ~sckPrev_q;
    assign sckFall  = ~sckSync_q[1] & sckPrev_q;
    assign loadRise = loadSync_q[1] & ~loadPrev_q;
    assign loadFall = ~loadSync_q[1] & loadPrev_q;

    // Effect of this cycle's sck rise, so a coincident load fall judges the frame including that bit.
    always_comb begin
        cntInc   = bitCnt_q;
        ovfInc   = ovf_q;
        shiftInc = inShift_q;
        if (sckRise) begin
            shiftInc = {inShift_q[FRAME_W-2:0], sdiSync_q[1]};
            if (bitCnt_q == CNT_W'(FRAME_W)) begin
                ovfInc = 1'b1;
            end else begin
                cntInc = bitCnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        ovf_d      = ovf_q;
        inShift_d  = inShift_q;
        outShift_d = outShift_q;
        outCnt_d   = outCnt_q;
        done_d     = done_q;
        err_d      = err_q;
        coreKey_d  = coreKey_q;
        corePt_d   = corePt_q;
`ifdef AES_SPI_KEY_REUSE_EN
        keyValid_d = keyValid_q;
`endif
        case (state_q)
            IDLE: begin
                if (loadRise) state_d = SHIFT_IN;
            end
            SHIFT_IN: begin
                bitCnt_d  = cntInc;
                ovf_d     = ovfInc;
                inShift_d = shiftInc;
                if (loadFall) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    if (!ovfInc && cntInc == CNT_W'(FRAME_W)) begin
                        corePt_d  = shiftInc[FRAME_W-1 -: DATA_W];
                        coreKey_d = shiftInc[KEY_W-1:0];
                        state_d   = START;
                        err_d     = 1'b0;
`ifdef AES_SPI_KEY_REUSE_EN
                        keyValid_d = 1'b1;
                    end else if (!ovfInc && cntInc == CNT_W'(DATA_W) && keyValid_q) begin
                        corePt_d = shiftInc[DATA_W-1:0];
                        state_d  = START;
                        err_d    = 1'b0;
`endif
                    end
                end
            end
            START: begin
                state_d = WAIT_CORE;
            end
            WAIT_CORE: begin
                // core_start is registered and is still high in the first cycle here; a stale level done is ignored then.
                if (loadRise) begin
                    state_d = SHIFT_IN;
                end else if (bus.core_done && !coreStart_q) begin
                    outShift_d = bus.core_ct;
                    outCnt_d   = '0;
                    done_d     = 1'b1;
                    state_d    = SHIFT_OUT;
                end
            end
            SHIFT_OUT: begin
                if (loadRise) begin
                    done_d  = 1'b0;
                    state_d = SHIFT_IN;
                end else if (sckFall) begin
                    outShift_d = {outShift_q[DATA_W-2:0], 1'b0};
                    outCnt_d   = outCnt_q + OCNT_W'(1);
                    if (outCnt_q == OCNT_W'(DATA_W - 1)) begin
                        done_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == SHIFT_IN && state_q != SHIFT_IN) begin
            bitCnt_d   = '0;
            ovf_d      = 1'b0;
            inShift_d  = '0;
            outShift_d = '0;
            err_d      = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            ovf_q       <= 1'b0;
            inShift_q   <= '0;
            outShift_q  <= '0;
            outCnt_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            coreStart_q <= 1'b0;
            coreKey_q   <= '0;
            corePt_q    <= '0;
`ifdef AES_SPI_KEY_REUSE_EN
            keyValid_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            ovf_q       <= ovf_d;
            inShift_q   <= inShift_d;
            outShift_q  <= outShift_d;
            outCnt_q    <= outCnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            coreStart_q <= (state_q == START);
            coreKey_q   <= coreKey_d;
            corePt_q    <= corePt_d;
`ifdef AES_SPI_KEY_REUSE_EN
            keyValid_q  <= keyValid_d;
`endif
        end
    end

    assign bus.sdo        = outShift_q[DATA_W-1];
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.core_start = coreStart_q;
    assign bus.core_key   = coreKey_q;
    assign bus.core_pt    = corePt_q;
endmodule

// File: tb/tb_aes_spi_if.sv
// Bench for aes_spi_if at all three key widths: FIPS-197 frames, random frames, bad lengths, abort, reset, key reuse.
// The bench plays both the SPI master and the AES core; AES_SPI_KEY_REUSE_EN changes the frame-legality model.
module tb_aes_spi_if;
`ifdef AES_SPI_KEY_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT_R   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KEY128 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KEY192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset;
    logic         sck, sdi, load, coreDone;
    logic [127:0] coreCt;
    int           sel;
    int           checks = 0;
    int           errors = 0;
    int           startPulses;
    bit           lastLegal;

    logic [255:0] mKey [3];
    logic [127:0] mPt [3];
    bit           mKeyValid [3];

    logic         oSdo, oDone, oErr, oStart;
    logic [255:0] oKey;
    logic [127:0] oPt;

    always #5 clk = ~clk;

    aes_spi_if_if #(.KEY_W(128), .DATA_W(128)) b0 ();
    aes_spi_if_if #(.KEY_W(192), .DATA_W(128)) b1 ();
    aes_spi_if_if #(.KEY_W(256), .DATA_W(128)) b2 ();

    aes_spi_if #(.KEY_W(128), .DATA_W(128)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
    aes_spi_if #(.KEY_W(192), .DATA_W(128)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
    aes_spi_if #(.KEY_W(256), .DATA_W(128)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));

    // SPI pins are shared; only the selected instance sees load and core_done.
    assign b0.sck = sck;  assign b0.sdi = sdi;  assign b0.load = load && sel == 0;
    assign b1.sck = sck;  assign b1.sdi = sdi;  assign b1.load = load && sel == 1;
    assign b2.sck = sck;  assign b2.sdi = sdi;  assign b2.load = load && sel == 2;
    assign b0.core_done = coreDone && sel == 0;  assign b0.core_ct = coreCt;
    assign b1.core_done = coreDone && sel == 1;  assign b1.core_ct = coreCt;
    assign b2.core_done = coreDone && sel == 2;  assign b2.core_ct = coreCt;

    always_comb begin
        oSdo = b0.sdo;  oDone = b0.done;  oErr = b0.err;  oStart = b0.core_start;
        oKey = 256'(b0.core_key);  oPt = b0.core_pt;
        if (sel == 1) begin
            oSdo = b1.sdo;  oDone = b1.done;  oErr = b1.err;  oStart = b1.core_start;
            oKey = 256'(b1.core_key);  oPt = b1.core_pt;
        end else if (sel == 2) begin
            oSdo = b2.sdo;  oDone = b2.done;  oErr = b2.err;  oStart = b2.core_start;
            oKey = 256'(b2.core_key);  oPt = b2.core_pt;
        end
    end

    function automatic int keyW(input int s);
        return (s == 0) ? 128 : (s == 1) ? 192 : 256;
    endfunction

    function automatic logic [511:0] frameOf(input logic [127:0] pt, input logic [255:0] key, input int kw);
        return (512'(pt) << kw) | 512'(key);
    endfunction

    // Stand-in for the AES core: known FIPS-197 answers, otherwise an arbitrary mix of key and plaintext.
    function automatic logic [127:0] coreModel(input logic [255:0] key, input logic [127:0] pt);
        if (pt == PT_C && key == KEY128) return CT128;
        if (pt == PT_C && key == KEY192) return CT192;
        if (pt == PT_C && key == KEY256) return CT256;
        return {pt[63:0], pt[127:64]} ^ key[127:0] ^ key[255:128] ^ 128'h5a5a_0f0f_c3c3_9696_a5a5_f0f0_3c3c_6969;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Shift len bits of vec MSB-first inside a load window, then count core_start pulses.
    task automatic applyStimulus(input int len, input logic [511:0] vec);
        load = 1'b1;
        tick(4);
        for (int i = len - 1; i >= 0; i--) begin
            sdi = vec[i];
            tick($urandom_range(4, 5));
            sck = 1'b1;
            tick($urandom_range(4, 5));
            sck = 1'b0;
        end
        tick(4);
        load = 1'b0;
        startPulses = 0;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            if (oStart) startPulses++;
        end
    endtask

    task automatic runFrame(input int len, input logic [511:0] vec);
        int kw;
        bit legalFull, legalReuse;
        kw = keyW(sel);
        legalFull  = (len == 128 + kw);
        legalReuse = REUSE && len == 128 && mKeyValid[sel];
        applyStimulus(len, vec);
        if (legalFull) begin
            mPt[sel]       = vec[len-1 -: 128];
            mKey[sel]      = 256'(vec & ((512'd1 << kw) - 512'd1));
            mKeyValid[sel] = 1'b1;
        end else if (legalReuse) begin
            mPt[sel] = vec[127:0];
        end
        lastLegal = legalFull || legalReuse;
        checkOutput("startPulses", 256'(startPulses), 256'(lastLegal ? 1 : 0));
        checkOutput("err", 256'(oErr), 256'(!lastLegal));
        checkOutput("coreKey", oKey, mKey[sel]);
        checkOutput("corePt", oPt, mPt[sel]);
    endtask

    task automatic respondCore();
        tick(3);
        coreCt   = coreModel(oKey, oPt);
        coreDone = 1'b1;
        tick(1);
        coreDone = 1'b0;
        checkOutput("doneSet", 256'(oDone), 256'(1'b1));
    endtask

    task automatic readOut(input int nbits, output logic [127:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            got[127 - i] = oSdo;
            sck = 1'b1;
            tick($urandom_range(4, 5));
            sck = 1'b0;
            tick($urandom_range(4, 5));
        end
    endtask

    task automatic fullRead(input string tag, input logic [127:0] exp);
        logic [127:0] got;
        respondCore();
        readOut(128, got);
        checkOutput(tag, 256'(got), 256'(exp));
        checkOutput("doneClr", 256'(oDone), 256'(1'b0));
    endtask

    task automatic checkResetValues();
        checkOutput("rstSdo", 256'(oSdo), 256'(1'b0));
        checkOutput("rstDone", 256'(oDone), 256'(1'b0));
        checkOutput("rstErr", 256'(oErr), 256'(1'b0));
        checkOutput("rstStart", 256'(oStart), 256'(1'b0));
        checkOutput("rstKey", oKey, 256'(0));
        checkOutput("rstPt", 256'(oPt), 256'(0));
    endtask

    initial begin
        logic [127:0] got;
        logic [127:0] ct;
        bit dropped;
        reset = 1'b0;  sck = 1'b0;  sdi = 1'b0;  load = 1'b0;
        coreDone = 1'b0;  coreCt = '0;  sel = 0;
        for (int k = 0; k < 3; k++) begin
            mKey[k] = '0;  mPt[k] = '0;  mKeyValid[k] = 1'b0;
        end
        tick(3);
        checkResetValues();
        reset = 1'b1;
        tick(3);

        // FIPS-197 vectors at each key width
        sel = 0;  runFrame(256, frameOf(PT_C, KEY128, 128));  fullRead("ctC1", CT128);
        sel = 2;  runFrame(384, frameOf(PT_C, KEY256, 256));  fullRead("ctC3", CT256);
        sel = 1;  runFrame(320, frameOf(PT_C, KEY192, 192));  fullRead("ctC2", CT192);

        // Random frames against the reference model
        sel = 0;
        for (int r = 0; r < 3; r++) begin
            runFrame(256, frameOf(rand128(), 256'(rand128()), 128));
            fullRead("ctRand", coreModel(mKey[0], mPt[0]));
        end

        // One bit short and one bit long
        runFrame(255, {rand128(), rand128(), rand128(), rand128()});
        runFrame(257, {rand128(), rand128(), rand128(), rand128()});

        // Abort a readout part way, then a clean frame
        runFrame(256, frameOf(PT_C, KEY128, 128));
        respondCore();
        readOut(40, got);
        ct = CT128;
        checkOutput("partialRead", 256'(got[127:88]), 256'(ct[127:88]));
        load = 1'b1;
        dropped = 1'b0;
        for (int c = 0; c < 4 && !dropped; c++) begin
            tick(1);
            if (!oDone) dropped = 1'b1;
        end
        checkOutput("abortDone", 256'(dropped), 256'(1'b1));
        runFrame(256, frameOf(PT_C, KEY128, 128));
        fullRead("ctAfterAbort", CT128);

        // Reset pulse in the middle of a frame
        load = 1'b1;
        tick(4);
        for (int i = 0; i < 20; i++) begin
            sdi = 1'($urandom_range(0, 1));
            tick(4);  sck = 1'b1;  tick(4);  sck = 1'b0;
        end
        reset = 1'b0;
        tick(1);
        load = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mKey[k] = '0;  mPt[k] = '0;  mKeyValid[k] = 1'b0;
        end
        tick(4);
        checkResetValues();

        // Plaintext-only frames: no key yet, then after a full frame
        runFrame(128, 512'(PT_R));
        runFrame(256, frameOf(PT_C, KEY128, 128));
        fullRead("ctC1Again", CT128);
        runFrame(128, 512'(PT_R));
        if (lastLegal) fullRead("ctReuse", coreModel(mKey[0], mPt[0]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
